// File: rtl/config_initiator.sv
// rtl/config_initiator.sv - OCP configuration-bus master fed by a request FIFO
// Issues one buffered read/write at a time and returns each completion in order.
module config_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  ocp_config_m_MCmd,
  output logic [31:0] ocp_config_m_MAddr,
  output logic [31:0] ocp_config_m_MData,
  output logic [3:0]  ocp_config_m_MByteEn,
  output logic        ocp_config_m_MRespAccept,
  input  logic [1:0]  ocp_config_s_SResp,
  input  logic [31:0] ocp_config_s_SData,
  input  logic        ocp_config_s_SCmdAccept
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           cmd_wr_q;
  logic [2:0]     mcmd_q;
  logic [31:0]    maddr_q;
  logic [31:0]    mdata_q;
  logic [3:0]     mbyteen_q;
  logic           mrespaccept_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_rdata_q;
  logic           rsp_err_q;

  logic           fifo_wr_q    [FIFO_DEPTH];
  logic [13:0]    fifo_addr_q  [FIFO_DEPTH];
  logic [31:0]    fifo_wdata_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           fifo_empty, fifo_full, push, pop;
  logic           head_wr;
  logic [13:0]    head_addr;
  logic [31:0]    head_wdata;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = req_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

  assign head_wr    = fifo_wr_q[rd_ptr_q[AW-1:0]];
  assign head_addr  = fifo_addr_q[rd_ptr_q[AW-1:0]];
  assign head_wdata = fifo_wdata_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q[AW-1:0]]    <= req_wr;
      fifo_addr_q[wr_ptr_q[AW-1:0]]  <= req_addr;
      fifo_wdata_q[wr_ptr_q[AW-1:0]] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_wr_q      <= 1'b0;
      mcmd_q        <= 3'b000;
      maddr_q       <= '0;
      mdata_q       <= '0;
      mbyteen_q     <= 4'b0000;
      mrespaccept_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_wr_q  <= head_wr;
            mcmd_q    <= head_wr ? 3'b001 : 3'b010;
            maddr_q   <= {13'b0, head_addr, 5'b0};
            mdata_q   <= head_wr ? head_wdata : 32'h0;
            mbyteen_q <= 4'b1111;
            cnt_q     <= '0;
            state_q   <= S_CMD;
          end
        end
        S_CMD: begin
          if (ocp_config_s_SCmdAccept || cnt_q == CNT_LAST) begin
            mcmd_q    <= 3'b000;
            maddr_q   <= '0;
            mdata_q   <= '0;
            mbyteen_q <= 4'b0000;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
          // Accept wins over a timeout landing in the same cycle.
          if (ocp_config_s_SCmdAccept) begin
            mrespaccept_q <= 1'b1;
            state_q       <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_RESP: begin
          if (ocp_config_s_SResp != 2'b00) begin
            mrespaccept_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= (cmd_wr_q || ocp_config_s_SResp[1]) ? 32'h0 : ocp_config_s_SData;
            rsp_err_q     <= ocp_config_s_SResp[1];
            cnt_q         <= '0;
            state_q       <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            mrespaccept_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready                = !fifo_full;
  assign busy                     = !fifo_empty || (state_q != S_IDLE);
  assign rsp_valid                = rsp_valid_q;
  assign rsp_rdata                = rsp_rdata_q;
  assign rsp_err                  = rsp_err_q;
  assign ocp_config_m_MCmd        = mcmd_q;
  assign ocp_config_m_MAddr       = maddr_q;
  assign ocp_config_m_MData       = mdata_q;
  assign ocp_config_m_MByteEn     = mbyteen_q;
  assign ocp_config_m_MRespAccept = mrespaccept_q;

endmodule
